load_store_unit: RTL and testbench

Initiator for the single-cycle-response data memory: accepts one load/store from the core, converts it into a masked word request on the memory port, waits for `mem_valid`, then returns aligned, sign/zero-extended load data. Sits between the execute stage and the data memory wrapper. Issues one transaction at a time and stalls the core via `lsu_ready` while busy.

---
 rtl/load_store_unit.sv | 165 ++++++++++++++++
 tb/tb_load_store_unit.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: one masked word access at a time, 3-cycle latency (accept->done) with a 1-cycle memory.
// lsu_ready is high only in IDLE; requests while busy are ignored. Optional LSU_MISALIGN_TRAP_EN traps misaligned ops.
module load_store_unit #(
  parameter int ADDR_W         = 8,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lsu_req,
  input  logic              lsu_we,
  input  logic [2:0]        lsu_funct3,
  input  logic [31:0]       lsu_addr,
  input  logic [31:0]       lsu_wdata,
  output logic              lsu_ready,
  output logic              lsu_done,
  output logic [31:0]       lsu_rdata,
  output logic              lsu_err,
  output logic              mem_request,
  output logic              mem_we_re,
  output logic [3:0]        mem_mask,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       mem_data_in,
  input  logic              mem_valid,
  input  logic [31:0]       mem_data_out
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  state_t state, state_nxt;

  logic              we_q;
  logic [2:0]        funct3_q;
  logic [1:0]        lane_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [3:0]        mask_q;
  logic [31:0]       wdata_q;
  logic [CW-1:0]     cnt_q;
  logic [31:0]       rdata_q;
  logic              err_q;

  logic        illegal, misaligned, accept_err;
  logic [1:0]  lane;
  logic [3:0]  mask;
  logic [31:0] lane_bits, wshift, rshift, load_val;

  logic unused_addr_hi;
  assign unused_addr_hi = ^lsu_addr[31:ADDR_W+2];

  // Decode of the incoming op; lane is the forcibly aligned byte offset.
  always_comb begin
    illegal    = 1'b0;
    misaligned = 1'b0;
    lane       = lsu_addr[1:0];
    mask       = 4'b1111;
    case (lsu_funct3)
      3'b000, 3'b001, 3'b010: illegal = 1'b0;
      3'b100, 3'b101:         illegal = lsu_we;
      default:                illegal = 1'b1;
    endcase
    case (lsu_funct3[1:0])
      2'b00: begin
        lane = lsu_addr[1:0];
        mask = 4'b0001 << lane;
      end
      2'b01: begin
        lane = {lsu_addr[1], 1'b0};
        mask = 4'b0011 << lane;
      end
      default: begin
        lane = 2'b00;
        mask = 4'b1111;
      end
    endcase
`ifdef LSU_MISALIGN_TRAP_EN
    misaligned = ((lsu_funct3[1:0] == 2'b01) && lsu_addr[0]) ||
                 ((lsu_funct3[1:0] == 2'b10) && (lsu_addr[1:0] != 2'b00));
`endif
    accept_err = illegal | misaligned;
    lane_bits  = {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};
    wshift     = (lsu_wdata << {lane, 3'b000}) & lane_bits;
  end

  always_comb begin
    rshift   = mem_data_out >> {lane_q, 3'b000};
    load_val = rshift;
    case (funct3_q)
      3'b000:  load_val = {{24{rshift[7]}}, rshift[7:0]};
      3'b001:  load_val = {{16{rshift[15]}}, rshift[15:0]};
      3'b100:  load_val = {24'd0, rshift[7:0]};
      3'b101:  load_val = {16'd0, rshift[15:0]};
      default: load_val = rshift;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (lsu_req) state_nxt = accept_err ? S_DONE : S_REQ;
      S_REQ:  state_nxt = S_WAIT;
      S_WAIT: if (mem_valid || (cnt_q == CNT_LAST)) state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q     <= 1'b0;
      funct3_q <= 3'd0;
      lane_q   <= 2'd0;
      waddr_q  <= '0;
      mask_q   <= 4'd0;
      wdata_q  <= 32'd0;
      cnt_q    <= '0;
      rdata_q  <= 32'd0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (lsu_req) begin
          we_q     <= lsu_we;
          funct3_q <= lsu_funct3;
          lane_q   <= lane;
          waddr_q  <= lsu_addr[ADDR_W+1:2];
          mask_q   <= mask;
          wdata_q  <= wshift;
          err_q    <= accept_err;
          rdata_q  <= 32'd0;
        end
        S_REQ: cnt_q <= '0;
        S_WAIT: begin
          if (mem_valid) begin
            rdata_q <= we_q ? 32'd0 : load_val;
            err_q   <= 1'b0;
          end else if (cnt_q == CNT_LAST) begin
            rdata_q <= 32'd0;
            err_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Memory-side outputs are gated so the port is quiet outside REQ.
  assign lsu_ready   = (state == S_IDLE);
  assign lsu_done    = (state == S_DONE);
  assign lsu_rdata   = lsu_done ? rdata_q : 32'd0;
  assign lsu_err     = lsu_done & err_q;
  assign mem_request = (state == S_REQ);
  assign mem_we_re   = mem_request & we_q;
  assign mem_mask    = mem_request ? mask_q : 4'd0;
  assign mem_address = mem_request ? waddr_q : '0;
  assign mem_data_in = mem_request ? wdata_q : 32'd0;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit (1-cycle memory driven by the bench).
module tb_load_store_unit;
  localparam int ADDR_W = 8;
  localparam int TO     = 15;

  logic              clk = 1'b0;
  logic              rst;
  logic              lsu_req, lsu_we;
  logic [2:0]        lsu_funct3;
  logic [31:0]       lsu_addr, lsu_wdata;
  logic              lsu_ready, lsu_done, lsu_err;
  logic [31:0]       lsu_rdata;
  logic              mem_request, mem_we_re;
  logic [3:0]        mem_mask;
  logic [ADDR_W-1:0] mem_address;
  logic [31:0]       mem_data_in;
  logic              mem_valid;
  logic [31:0]       mem_data_out;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_funct3(lsu_funct3),
    .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
    .lsu_ready(lsu_ready), .lsu_done(lsu_done), .lsu_rdata(lsu_rdata), .lsu_err(lsu_err),
    .mem_request(mem_request), .mem_we_re(mem_we_re), .mem_mask(mem_mask),
    .mem_address(mem_address), .mem_data_in(mem_data_in),
    .mem_valid(mem_valid), .mem_data_out(mem_data_out)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents an op for exactly one accept edge; returns 1 time unit after that edge.
  task automatic accept(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
    step();
    lsu_req = 1'b1; lsu_we = we; lsu_funct3 = f3; lsu_addr = addr; lsu_wdata = wd;
    step();
    lsu_req = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    lsu_req = 1'b0; lsu_we = 1'b0; lsu_funct3 = 3'd0; lsu_addr = 32'd0; lsu_wdata = 32'd0;
    mem_valid = 1'b0; mem_data_out = 32'd0;
    #1;
    n_cmp++;
    if (lsu_ready !== 1'b1 || mem_request !== 1'b0 || lsu_done !== 1'b0 || lsu_rdata !== 32'd0 || lsu_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs got rdy=%b req=%b done=%b rdata=%h err=%b need 1 0 0 0 0",
               lsu_ready, mem_request, lsu_done, lsu_rdata, lsu_err);
    end
    step(); step();
    rst = 1'b0;
    step();
    n_cmp++;
    if (lsu_ready !== 1'b1 || mem_mask !== 4'd0 || mem_address !== '0) begin
      n_fail++;
      $display("FAIL post_reset got rdy=%b mask=%b addr=%h need 1 0000 00", lsu_ready, mem_mask, mem_address);
    end
  endtask

  task automatic test_store_byte();
    accept(1'b1, 3'b000, 32'h0000_0013, 32'h0000_00AB);
    n_cmp++;
    if (mem_request !== 1'b1 || mem_we_re !== 1'b1 || mem_mask !== 4'b1000 ||
        mem_address !== 8'h04 || mem_data_in !== 32'hAB00_0000 || lsu_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL sb_request got req=%b we=%b mask=%b addr=%h data=%h rdy=%b need 1 1 1000 04 ab000000 0",
               mem_request, mem_we_re, mem_mask, mem_address, mem_data_in, lsu_ready);
    end
    step();
    n_cmp++;
    if (mem_request !== 1'b0 || lsu_done !== 1'b0) begin
      n_fail++;
      $display("FAIL sb_wait got req=%b done=%b need 0 0", mem_request, lsu_done);
    end
    mem_valid = 1'b1; mem_data_out = 32'hDEAD_BEEF;
    step();
    mem_valid = 1'b0; mem_data_out = 32'd0;
    n_cmp++;
    if (lsu_done !== 1'b1 || lsu_err !== 1'b0 || lsu_rdata !== 32'd0) begin
      n_fail++;
      $display("FAIL sb_done got done=%b err=%b rdata=%h need 1 0 00000000", lsu_done, lsu_err, lsu_rdata);
    end
    step();
    n_cmp++;
    if (lsu_done !== 1'b0 || lsu_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL sb_idle got done=%b rdy=%b need 0 1", lsu_done, lsu_ready);
    end
  endtask

  task automatic test_loads();
    logic [2:0]  f3  [5] = '{3'b000, 3'b100, 3'b010, 3'b001, 3'b101};
    logic [31:0] ad  [5] = '{32'h12, 32'h12, 32'h10, 32'h16, 32'h16};
    logic [31:0] wd  [5] = '{32'h0080_0000, 32'h0080_0000, 32'h1234_5678, 32'h8001_0000, 32'h8001_0000};
    logic [3:0]  em  [5] = '{4'b0100, 4'b0100, 4'b1111, 4'b1100, 4'b1100};
    logic [7:0]  ea  [5] = '{8'h04, 8'h04, 8'h04, 8'h05, 8'h05};
    logic [31:0] exp [5] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h1234_5678, 32'hFFFF_8001, 32'h0000_8001};
    for (int i = 0; i < 5; i++) begin
      accept(1'b0, f3[i], ad[i], 32'hFFFF_FFFF);
      n_cmp++;
      if (mem_request !== 1'b1 || mem_we_re !== 1'b0 || mem_mask !== em[i] || mem_address !== ea[i]) begin
        n_fail++;
        $display("FAIL load_req[%0d] got req=%b we=%b mask=%b addr=%h need 1 0 %b %h",
                 i, mem_request, mem_we_re, mem_mask, mem_address, em[i], ea[i]);
      end
      step();
      mem_valid = 1'b1; mem_data_out = wd[i];
      step();
      mem_valid = 1'b0; mem_data_out = 32'd0;
      n_cmp++;
      if (lsu_done !== 1'b1 || lsu_err !== 1'b0 || lsu_rdata !== exp[i]) begin
        n_fail++;
        $display("FAIL load_data[%0d] got done=%b err=%b rdata=%h need 1 0 %h",
                 i, lsu_done, lsu_err, lsu_rdata, exp[i]);
      end
      step();
    end
  endtask

  task automatic test_timeout();
    logic early;
    early = 1'b0;
    accept(1'b0, 3'b010, 32'h20, 32'd0);
    for (int k = 0; k < TO; k++) begin
      step();
      if (lsu_done !== 1'b0) early = 1'b1;
    end
    n_cmp++;
    if (early !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_early got done before %0d wait cycles need none", TO);
    end
    step();
    n_cmp++;
    if (lsu_done !== 1'b1 || lsu_err !== 1'b1 || lsu_rdata !== 32'd0) begin
      n_fail++;
      $display("FAIL timeout_done got done=%b err=%b rdata=%h need 1 1 00000000", lsu_done, lsu_err, lsu_rdata);
    end
    step();
    accept(1'b0, 3'b010, 32'h10, 32'd0);
    step();
    mem_valid = 1'b1; mem_data_out = 32'h0BAD_F00D;
    step();
    mem_valid = 1'b0; mem_data_out = 32'd0;
    n_cmp++;
    if (lsu_done !== 1'b1 || lsu_err !== 1'b0 || lsu_rdata !== 32'h0BAD_F00D) begin
      n_fail++;
      $display("FAIL after_timeout got done=%b err=%b rdata=%h need 1 0 0badf00d", lsu_done, lsu_err, lsu_rdata);
    end
    step();
  endtask

  task automatic test_misalign();
    accept(1'b0, 3'b010, 32'h2, 32'd0);
`ifdef LSU_MISALIGN_TRAP_EN
    n_cmp++;
    if (mem_request !== 1'b0 || lsu_done !== 1'b1 || lsu_err !== 1'b1) begin
      n_fail++;
      $display("FAIL misalign_trap got req=%b done=%b err=%b need 0 1 1", mem_request, lsu_done, lsu_err);
    end
    step();
`else
    n_cmp++;
    if (mem_request !== 1'b1 || mem_address !== 8'h00 || mem_mask !== 4'b1111) begin
      n_fail++;
      $display("FAIL misalign_req got req=%b addr=%h mask=%b need 1 00 1111", mem_request, mem_address, mem_mask);
    end
    step();
    mem_valid = 1'b1; mem_data_out = 32'hCAFE_BABE;
    step();
    mem_valid = 1'b0; mem_data_out = 32'd0;
    n_cmp++;
    if (lsu_done !== 1'b1 || lsu_err !== 1'b0 || lsu_rdata !== 32'hCAFE_BABE) begin
      n_fail++;
      $display("FAIL misalign_done got done=%b err=%b rdata=%h need 1 0 cafebabe", lsu_done, lsu_err, lsu_rdata);
    end
    step();
`endif
  endtask

  task automatic test_reset_mid();
    logic saw_done;
    saw_done = 1'b0;
    accept(1'b0, 3'b010, 32'h10, 32'd0);
    rst = 1'b1;
    #1;
    n_cmp++;
    if (mem_request !== 1'b0 || lsu_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_req got req=%b rdy=%b need 0 1", mem_request, lsu_ready);
    end
    step();
    rst = 1'b0;
    accept(1'b0, 3'b010, 32'h10, 32'd0);
    step();
    rst = 1'b1;
    mem_valid = 1'b1; mem_data_out = 32'h1111_2222;
    #1;
    n_cmp++;
    if (mem_request !== 1'b0 || lsu_ready !== 1'b1 || lsu_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_in_wait got req=%b rdy=%b done=%b need 0 1 0", mem_request, lsu_ready, lsu_done);
    end
    step();
    mem_valid = 1'b0; mem_data_out = 32'd0;
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (lsu_done !== 1'b0) saw_done = 1'b1;
    end
    n_cmp++;
    if (saw_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_no_done got a done pulse after reset need none");
    end
  endtask

  task automatic test_illegal();
    accept(1'b0, 3'b011, 32'h10, 32'd0);
    n_cmp++;
    if (mem_request !== 1'b0 || lsu_done !== 1'b1 || lsu_err !== 1'b1 || lsu_rdata !== 32'd0) begin
      n_fail++;
      $display("FAIL illegal_load got req=%b done=%b err=%b rdata=%h need 0 1 1 00000000",
               mem_request, lsu_done, lsu_err, lsu_rdata);
    end
    step();
    n_cmp++;
    if (lsu_ready !== 1'b1 || lsu_done !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal_idle got rdy=%b done=%b need 1 0", lsu_ready, lsu_done);
    end
    accept(1'b1, 3'b100, 32'h10, 32'h55);
    n_cmp++;
    if (mem_request !== 1'b0 || lsu_done !== 1'b1 || lsu_err !== 1'b1) begin
      n_fail++;
      $display("FAIL illegal_store got req=%b done=%b err=%b need 0 1 1", mem_request, lsu_done, lsu_err);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_store_byte();
    test_loads();
    test_timeout();
    test_misalign();
    test_reset_mid();
    test_illegal();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
